spi_frame_ctrl: RTL
===================

Name: spi_frame_ctrl

Overview:
- Clock-domain controller that sequences the receive-only SPI shift register (sck-clocked, 2×16-bit p1/p2) for the core logic on clk.
- Synchronizes raw load/sck and counts sck rising edges per frame.
- Captures the receiver's held p1/p2 when load deasserts, and only when exactly FRAME_BITS bits arrived. Presents them to the consumer through a valid/ready handshake with error and overrun reporting.

Parameters:
W, 16, width of each player word
FRAME_BITS, 32, required sck rising edges per frame (2*W)
SYNC_STAGES, 2, synchronizer depth for load and sck (≥2)
TIMEOUT_CYCLES, 1000000, max clk cycles load may stay high in one frame

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
sck  in  1  raw SPI clock from MCU (asynchronous to clk)
load  in  1  raw frame-enable from MCU (asynchronous)
p1_in  in  W  p1 from SPI receiver (stable while load low)
p2_in  in  W  p2 from SPI receiver
p1  out  W  captured p1
p2  out  W  captured p2
valid  out  1  p1/p2 hold an unconsumed frame
ready  in  1  consumer accepts when valid&&ready
overrun  out  1  one-cycle pulse: new frame replaced an unconsumed one
frame_err  out  1  one-cycle pulse: bad bit count or timeout
err_cnt  out  8  saturating count of frame_err pulses
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, reset_n=0 at clk edge): p1=p2=0, valid=0, overrun=0, frame_err=0, err_cnt=0, FSM=IDLE, bit_cnt=0, timer=0. Load synchronizer flops and their delayed copy reset to 1; sck synchronizer flops reset to 0. As a result a frame already in progress at reset release produces no rise and is ignored.
- Synchronization: SYNC_STAGES flops per input, plus one delay flop for edge detection. Rise = s&&!d; fall = !s&&d.
- Input timing: sck high and low phases must each be ≥ SYNC_STAGES+1 clk periods. Faster sck is out of spec.
- FSM states:
  - IDLE: on load rise → RECV; clear bit_cnt and timer.
  - RECV: each sck rise increments bit_cnt, which is 6-bit and saturates at 63. Timer increments every cycle.
    - On load fall → CAPTURE.
    - Else, when timer reaches TIMEOUT_CYCLES-1 → pulse frame_err, go to DRAIN.
    - If load fall and timeout occur in the same cycle, load fall wins.
  - CAPTURE (1 cycle):
    - If bit_cnt==FRAME_BITS: latch p1<=p1_in, p2<=p2_in, valid<=1.
    - Else: pulse frame_err; outputs and valid unchanged.
    - Always → IDLE.
  - DRAIN: ignore sck; on load fall → IDLE with no capture.
- Latency: valid rises on the clk edge SYNC_STAGES+2 edges after the first edge that samples raw load low.
- Handshake:
  - valid clears on the edge after valid&&ready.
  - Capture while valid&&!ready: data overwritten, valid stays 1, overrun pulses.
  - Capture in the same cycle as valid&&ready: old frame consumed, new data loaded, valid stays 1, no overrun.
  - ready is ignored while valid=0.
- err_cnt: +1 per frame_err pulse, saturates at 255.
- busy = (FSM != IDLE).
- Load re-rise while in CAPTURE is not seen: CAPTURE is one cycle, and the MCU must hold load low ≥ SYNC_STAGES+3 clk between frames.

Decomposition:
- Package spi_ctrl_pkg: state enum {IDLE, RECV, CAPTURE, DRAIN}, ERR_CNT_W=8, BIT_CNT_W=6.
- Sub-module sync_edge: SYNC_STAGES-deep synchronizer with delay flop, reset value parameter, rise/fall outputs. Instantiated for load (reset 1) and sck (reset 0).

Test Plan:
- Reset: drive reset_n=0 for 2 clk with load=1 → p1=p2=0, valid=0, err_cnt=0, busy=0. Release with load still high → no activity until next load rise.
- Good frame: p1_in=0x0102, p2_in=0x0304, 32 sck, load low, ready=0 → valid=1 exactly SYNC_STAGES+2 edges after load sampled low, p1=0x0102, p2=0x0304, frame_err=0. Pulse ready=1 → valid=0 next edge.
- Short frame: 31 sck → frame_err pulses once, err_cnt=1, valid=0, p1/p2 unchanged. Repeat with 33 sck → err_cnt=2.
- Overrun: valid pending with 0x0102/0x0304, ready=0, second good frame 0xAAAA/0x5555 → overrun pulse, p1=0xAAAA, p2=0x5555, valid=1. Repeat with ready=1 in the capture cycle → no overrun, valid=1.
- Timeout (TIMEOUT_CYCLES=64): load high with no sck → frame_err at cycle 64, state DRAIN. Then 32 sck and load low → no capture. Next good frame captures normally.
- Reset mid-frame: assert reset_n=0 after bit 10 with load high, release, finish frame → no valid, no frame_err. Following good frame 0x1234/0x5678 → valid with those values.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and widths for the SPI frame controller.
package spi_ctrl_pkg;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  localparam int ERR_CNT_W = 8;
  localparam int BIT_CNT_W = 6;

endpackage : spi_ctrl_pkg

// File: rtl/spi_frame_ctrl_sync_edge.sv
// Multi-flop synchronizer with a delay flop and registered rise/fall pulses.
// The synchronizer chain and delay flop reset to RESET_VAL. If the raw input
// already sits at RESET_VAL when reset is released, no edge is reported.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Shift the raw input through the chain and register the edge pulses, so
  // downstream logic only ever sees flop outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, whatever the statement order.
    if (!reset_n) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      delay_q <= RESET_VAL;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      delay_q <= sync_s;
      rise    <= sync_s && !delay_q;
      fall    <= !sync_s && delay_q;
    end
  end

endmodule : sync_edge

// File: rtl/spi_frame_ctrl.sv
// Frame controller for a receive-only SPI shift register. It synchronizes
// load and sck, counts sck rises per frame, captures p1/p2 when the bit count
// is exact, and hands frames to the consumer over valid/ready.
module spi_frame_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int W              = 16,
  parameter int FRAME_BITS     = 2 * W,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sck,
  input  logic                 load,
  input  logic [W-1:0]         p1_in,
  input  logic [W-1:0]         p2_in,
  output logic [W-1:0]         p1,
  output logic [W-1:0]         p2,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] BITS_GOOD  = BIT_CNT_W'(FRAME_BITS);

  state_e               state, next_state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [TIMER_W-1:0]   timer;

  logic load_rise, load_fall;
  logic sck_rise, sck_fall_unused;

  logic clr_cnt;
  logic do_capture;
  logic do_err;

  // load idles high between frames, so its chain resets high: a frame already
  // running at reset release shows no rise and is ignored.
  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_load_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (load),
    .rise    (load_rise),
    .fall    (load_fall)
  );

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sck_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sck),
    .rise    (sck_rise),
    .fall    (sck_fall_unused)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    next_state = state;
    clr_cnt    = 1'b0;
    do_capture = 1'b0;
    do_err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_rise) begin
          next_state = RECV;
          clr_cnt    = 1'b1;
        end
      end
      RECV: begin
        // A load fall in the timeout cycle still ends the frame normally.
        if (load_fall) begin
          next_state = CAPTURE;
        end else if (timer == TIMER_LAST) begin
          next_state = DRAIN;
          do_err     = 1'b1;
        end
      end
      CAPTURE: begin
        next_state = IDLE;
        if (bit_cnt == BITS_GOOD) do_capture = 1'b1;
        else                      do_err     = 1'b1;
      end
      DRAIN: begin
        if (load_fall) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bit counter and frame timer: cleared at frame start, running in RECV.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      timer   <= '0;
    end else if (clr_cnt) begin
      bit_cnt <= '0;
      timer   <= '0;
    end else if (state == RECV) begin
      timer <= timer + 1'b1;
      if (sck_rise && (bit_cnt != '1)) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Output frame register, handshake, overrun and error reporting.
  always_ff @(posedge clk) begin
    // NOTE: only control and status flops need a reset value here; p1/p2 are
    // reset too because the consumer may look at them before the first frame.
    if (!reset_n) begin
      p1        <= '0;
      p2        <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= do_err;
      overrun   <= 1'b0;
      if (do_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;

      if (valid && ready) valid <= 1'b0;

      // A capture overrides the consume above; it is an overrun only if the
      // pending frame was not taken in this same cycle.
      if (do_capture) begin
        p1      <= p1_in;
        p2      <= p2_in;
        valid   <= 1'b1;
        overrun <= valid && !ready;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule : spi_frame_ctrl
